// File: rtl/kyber_mmio_pkg.sv
// Shared types and constants for the Baby Kyber MMIO front-end: sequencer states,
// core modes, register offsets, STATUS bit positions and operand/result word counts.
package kyber_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [1:0] MODE_NONE    = 2'd0;
    localparam logic [1:0] MODE_KEYGEN  = 2'd1;
    localparam logic [1:0] MODE_ENCRYPT = 2'd2;
    localparam logic [1:0] MODE_DECRYPT = 2'd3;

    localparam logic [31:0] OPD_OFF    = 32'h000;
    localparam logic [31:0] RES_OFF    = 32'h800;
    localparam logic [31:0] CTRL_OFF   = 32'hF00;
    localparam logic [31:0] STATUS_OFF = 32'hF04;

    localparam int CTRL_START_BIT = 8;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_TIMEOUT  = 2;
    localparam int ST_REJECTED = 3;
    localparam int ST_MODE_LO  = 4;

    // A, s, e, r, e1, e2, msg
    function automatic int opd_words(input int k, input int n);
        return k * k * n + 4 * k * n + n + 1;
    endfunction

    // pk (A-part + t), ciphertext (u, v), decoded message
    function automatic int res_words(input int k, input int n);
        return k * k * n + k * n + (k + 1) * n + 1;
    endfunction

endpackage

// File: rtl/kyber_mmio_ctrl_if.sv
// Request/response bus between a host master and the Kyber MMIO controller.
// A request transfers on a cycle with valid_Req && ready_Req; its response is a one-cycle
// valid_Resp pulse on the following cycle carrying data_Resp and err_Resp.
interface kyber_mmio_ctrl_if #(
    parameter int DW = 32
);
    logic              valid_Req;
    logic              ready_Req;
    logic              wen_Req;
    logic [31:0]       addr_Req;
    logic [DW-1:0]     data_Req;
    logic [DW/8-1:0]   bytelane_Req;
    logic              valid_Resp;
    logic [DW-1:0]     data_Resp;
    logic              err_Resp;

    modport master (
        output valid_Req, wen_Req, addr_Req, data_Req, bytelane_Req,
        input  ready_Req, valid_Resp, data_Resp, err_Resp
    );

    modport slave (
        input  valid_Req, wen_Req, addr_Req, data_Req, bytelane_Req,
        output ready_Req, valid_Resp, data_Resp, err_Resp
    );
endinterface

// File: rtl/kyber_bytelane_reg.sv
// DW-wide register whose bytes load independently under a per-byte enable.
module kyber_bytelane_reg
    import kyber_mmio_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW/8-1:0] be,
    input  logic [DW-1:0]   d,
    output logic [DW-1:0]   q
);
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        for (int b = 0; b < DW / 8; b++) begin
            if (be[b]) data_d[8*b +: 8] = d[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign q = data_q;
endmodule

// File: rtl/kyber_mmio_ctrl.sv
// MMIO front-end and sequencer for the Baby Kyber cores: staged operand writes, a CTRL
// write that commits staging to the live operands and starts a core, plus sticky status.
module kyber_mmio_ctrl
    import kyber_mmio_pkg::*;
#(
    parameter int          K         = 2,
    parameter int          N         = 4,
    parameter int          DW        = 32,
    parameter logic [31:0] BASE      = 32'h4000_7000,
    parameter int          TIMEOUT   = 1024,
    localparam int         OPD_WORDS = opd_words(K, N),
    localparam int         RES_WORDS = res_words(K, N)
) (
    input  logic                    clk,
    input  logic                    rst,
    kyber_mmio_ctrl_if.slave        bus,
    output logic [OPD_WORDS*DW-1:0] opd_flat,
    input  logic [RES_WORDS*DW-1:0] res_flat,
    output logic [1:0]              core_mode,
    output logic                    core_start,
    input  logic                    core_done,
    output logic                    irq,
    output state_t                  dbg_state
);
    localparam int              NB        = DW / 8;
    localparam int              OIW       = $clog2(OPD_WORDS);
    localparam int              RIW       = $clog2(RES_WORDS);
    localparam int              CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0]     OPD_BYTES = 32'(OPD_WORDS * 4);
    localparam logic [31:0]     RES_BYTES = 32'(RES_WORDS * 4);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d, tout_q, tout_d, rej_q, rej_d;
    logic            irq_q, irq_d, start_q, start_d;
    logic            valid_resp_q, valid_resp_d, err_resp_q, err_resp_d;
    logic [DW-1:0]   data_resp_q, data_resp_d;
    logic [DW-1:0]   stg_q  [OPD_WORDS];
    logic [DW-1:0]   live_q [OPD_WORDS];
    logic [DW-1:0]   live_d [OPD_WORDS];
    logic [DW-1:0]   res_w  [RES_WORDS];
    logic [NB-1:0]   stg_be [OPD_WORDS];

    logic [31:0]     off, res_off;
    logic            hit_opd, hit_res, hit_ctrl, hit_stat;
    logic            acc_err, accept, wr_ok, ctrl_go, ctrl_start;
    logic [OIW-1:0]  opd_idx;
    logic [RIW-1:0]  res_idx;
    logic [1:0]      ctrl_mode;
    logic [2:0]      w1c, w1c_clr;
    logic            done_set, tout_set, rej_set;
    logic [DW-1:0]   rdata, status;

    // Address decode works on the offset from BASE; anything below BASE wraps high and misses.
    assign off      = bus.addr_Req - BASE;
    assign res_off  = off - RES_OFF;
    assign hit_opd  = off < OPD_BYTES;
    assign hit_res  = (off >= RES_OFF) && (res_off < RES_BYTES);
    assign hit_ctrl = off == CTRL_OFF;
    assign hit_stat = off == STATUS_OFF;
    assign opd_idx  = off[OIW+1:2];
    assign res_idx  = res_off[RIW+1:2];

    // Control fields only count when their byte lane is enabled.
    assign ctrl_mode = bus.data_Req[1:0] & {2{bus.bytelane_Req[0]}};
    assign ctrl_go   = bus.data_Req[CTRL_START_BIT] & bus.bytelane_Req[CTRL_START_BIT/8];
    assign w1c       = bus.data_Req[3:1] & {3{bus.bytelane_Req[0]}};

    assign acc_err = (bus.addr_Req[1:0] != 2'b00)
                   || !(hit_opd || hit_res || hit_ctrl || hit_stat)
                   || (bus.wen_Req && hit_res)
                   || (bus.wen_Req && hit_ctrl && ctrl_go && ctrl_mode == MODE_NONE);

    assign bus.ready_Req = (state_q != COMMIT);
    assign accept        = bus.valid_Req && bus.ready_Req;
    assign wr_ok         = accept && bus.wen_Req && !acc_err;
    assign ctrl_start    = wr_ok && hit_ctrl && ctrl_go;
    assign w1c_clr       = (wr_ok && hit_stat) ? w1c : 3'b000;

    for (genvar i = 0; i < OPD_WORDS; i++) begin : g_stg
        assign stg_be[i] = (wr_ok && hit_opd && opd_idx == OIW'(i)) ? bus.bytelane_Req : '0;
        kyber_bytelane_reg #(.DW(DW)) u_reg (
            .clk (clk),
            .rst (rst),
            .be  (stg_be[i]),
            .d   (bus.data_Req),
            .q   (stg_q[i])
        );
        assign opd_flat[i*DW +: DW] = live_q[i];
    end

    for (genvar j = 0; j < RES_WORDS; j++) begin : g_res
        assign res_w[j] = res_flat[j*DW +: DW];
    end

    always_comb begin
        status                       = '0;
        status[ST_BUSY]              = (state_q != IDLE);
        status[ST_DONE]              = done_q;
        status[ST_TIMEOUT]           = tout_q;
        status[ST_REJECTED]          = rej_q;
        status[ST_MODE_LO +: 2]      = mode_q;
    end

    always_comb begin
        rdata = '0;
        if (!bus.wen_Req && !acc_err) begin
            if (hit_opd)       rdata = stg_q[opd_idx];
            else if (hit_res)  rdata = res_w[res_idx];
            else if (hit_ctrl) rdata = DW'(mode_q);
            else if (hit_stat) rdata = status;
        end
        valid_resp_d = accept;
        err_resp_d   = accept && acc_err;
        data_resp_d  = accept ? rdata : '0;
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        done_set = 1'b0;
        tout_set = 1'b0;
        rej_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    state_d = COMMIT;
                    mode_d  = ctrl_mode;
                end
            end
            COMMIT: begin
                state_d = RUN;
                cnt_d   = '0;
                start_d = 1'b1;
            end
            RUN: begin
                // A completion on the last allowed cycle still counts as done.
                if (core_done) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    tout_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (ctrl_start && state_q != IDLE) rej_set = 1'b1;
        done_d = (done_q & ~w1c_clr[0]) | done_set;
        tout_d = (tout_q & ~w1c_clr[1]) | tout_set;
        rej_d  = (rej_q  & ~w1c_clr[2]) | rej_set;
        irq_d  = done_d | tout_d;
        for (int i = 0; i < OPD_WORDS; i++) begin
            live_d[i] = (state_q == COMMIT) ? stg_q[i] : live_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= MODE_NONE;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            tout_q       <= 1'b0;
            rej_q        <= 1'b0;
            irq_q        <= 1'b0;
            start_q      <= 1'b0;
            valid_resp_q <= 1'b0;
            err_resp_q   <= 1'b0;
            data_resp_q  <= '0;
            for (int i = 0; i < OPD_WORDS; i++) live_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            tout_q       <= tout_d;
            rej_q        <= rej_d;
            irq_q        <= irq_d;
            start_q      <= start_d;
            valid_resp_q <= valid_resp_d;
            err_resp_q   <= err_resp_d;
            data_resp_q  <= data_resp_d;
            for (int i = 0; i < OPD_WORDS; i++) live_q[i] <= live_d[i];
        end
    end

    assign bus.valid_Resp = valid_resp_q;
    assign bus.data_Resp  = data_resp_q;
    assign bus.err_Resp   = err_resp_q;
    assign core_mode      = mode_q;
    assign core_start     = start_q;
    assign irq            = irq_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_kyber_mmio_ctrl.sv
// Randomized bench for kyber_mmio_ctrl against a register-map level reference model.
module tb_kyber_mmio_ctrl;
  import kyber_mmio_pkg::*;

  localparam int          K         = 2;
  localparam int          N         = 4;
  localparam int          DW        = 32;
  localparam int          NB        = DW / 8;
  localparam logic [31:0] BASE      = 32'h4000_7000;
  localparam int          TIMEOUT   = 32;
  localparam int          OPD_WORDS = K*K*N + K*N + K*N + K*N + K*N + N + 1;
  localparam int          RES_WORDS = K*K*N + K*N + (K+1)*N + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [OPD_WORDS*DW-1:0] opd_flat;
  logic [RES_WORDS*DW-1:0] res_flat;
  logic [1:0]              core_mode;
  logic                    core_start;
  logic                    core_done;
  logic                    irq;
  state_t                  dbg_state;

  kyber_mmio_ctrl_if #(.DW(DW)) bus ();

  kyber_mmio_ctrl #(.K(K), .N(N), .DW(DW), .BASE(BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .opd_flat   (opd_flat),
    .res_flat   (res_flat),
    .core_mode  (core_mode),
    .core_start (core_start),
    .core_done  (core_done),
    .irq        (irq),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: register map contents and sticky flags
  logic [DW-1:0] m_stg  [OPD_WORDS];
  logic [DW-1:0] m_live [OPD_WORDS];
  logic [DW-1:0] m_res  [RES_WORDS];
  logic [1:0]    m_mode;
  bit            m_busy, m_done, m_to, m_rej;

  logic [DW-1:0] rd_d;
  logic          rd_e, rd_v;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < NB; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_status();
    return {{(DW-6){1'b0}}, m_mode, m_rej, m_to, m_done, m_busy};
  endfunction

  function automatic logic [OPD_WORDS*DW-1:0] live_flat();
    logic [OPD_WORDS*DW-1:0] f;
    for (int i = 0; i < OPD_WORDS; i++) f[i*DW +: DW] = m_live[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < OPD_WORDS; i++) begin m_stg[i] = '0; m_live[i] = '0; end
    m_mode = 2'd0; m_busy = 0; m_done = 0; m_to = 0; m_rej = 0;
  endtask

  task automatic drive_res();
    for (int j = 0; j < RES_WORDS; j++) res_flat[j*DW +: DW] = m_res[j];
  endtask

  // single transfer: drive on negedge, wait for ready, sample response on the next negedge
  task automatic bus_xfer(input bit wen, input logic [31:0] addr, input logic [DW-1:0] data,
                          input logic [NB-1:0] be, output logic [DW-1:0] rdata,
                          output logic err, output logic rvalid);
    int w;
    @(negedge clk);
    bus.valid_Req = 1'b1; bus.wen_Req = wen; bus.addr_Req = addr;
    bus.data_Req = data; bus.bytelane_Req = be;
    w = 0;
    while (bus.ready_Req !== 1'b1 && w < 16) begin @(negedge clk); w++; end
    if (w == 16) begin
      n_checks++; n_errors++;
      $display("FAIL bus_ready_wait: ready_Req=%b, required 1 within 16 cycles", bus.ready_Req);
    end
    @(posedge clk);
    @(negedge clk);
    bus.valid_Req = 1'b0; bus.wen_Req = 1'b0;
    rvalid = bus.valid_Resp; rdata = bus.data_Resp; err = bus.err_Resp;
  endtask

  task automatic wr(input logic [31:0] off, input logic [DW-1:0] d, input logic [NB-1:0] be);
    bus_xfer(1'b1, BASE + off, d, be, rd_d, rd_e, rd_v);
  endtask

  task automatic rd(input logic [31:0] off);
    bus_xfer(1'b0, BASE + off, '0, '0, rd_d, rd_e, rd_v);
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (bus.ready_Req !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b, required 1", bus.ready_Req); end
    n_checks++; if ({bus.valid_Resp, bus.err_Resp, core_start, irq} !== 4'b0) begin n_errors++; $display("FAIL reset_pulses: got %b, required 0000", {bus.valid_Resp, bus.err_Resp, core_start, irq}); end
    n_checks++; if (bus.data_Resp !== '0 || core_mode !== 2'd0) begin n_errors++; $display("FAIL reset_data_mode: got %h/%0d, required 0/0", bus.data_Resp, core_mode); end
    n_checks++; if (opd_flat !== '0) begin n_errors++; $display("FAIL reset_opd_flat: got nonzero, required 0"); end
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d, required IDLE", dbg_state); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(STATUS_OFF);
    n_checks++; if (rd_v !== 1'b1 || rd_d !== exp_status()) begin n_errors++; $display("FAIL reset_status: got v=%b %h, required v=1 %h", rd_v, rd_d, exp_status()); end
  endtask

  task automatic test_bytelane();
    int idx; logic [DW-1:0] d; logic [NB-1:0] be;
    wr(OPD_OFF, 32'h1122_3344, 4'b0101);
    m_stg[0] = merge(m_stg[0], 32'h1122_3344, 4'b0101);
    n_checks++; if (rd_e !== 1'b0 || rd_d !== '0) begin n_errors++; $display("FAIL bl_write_resp: got err=%b data=%h, required 0/0", rd_e, rd_d); end
    rd(OPD_OFF);
    n_checks++; if (rd_d !== 32'h0022_0044) begin n_errors++; $display("FAIL bl_readback: got %h, required 00220044", rd_d); end
    n_checks++; if (opd_flat[DW-1:0] !== m_live[0]) begin n_errors++; $display("FAIL bl_live_unchanged: got %h, required %h", opd_flat[DW-1:0], m_live[0]); end
    wr(OPD_OFF, 32'hFFFF_FFFF, 4'b0000);
    n_checks++; if (rd_e !== 1'b0) begin n_errors++; $display("FAIL bl_zero_lane_err: got %b, required 0", rd_e); end
    rd(OPD_OFF);
    n_checks++; if (rd_d !== m_stg[0]) begin n_errors++; $display("FAIL bl_zero_lane_data: got %h, required %h", rd_d, m_stg[0]); end
    for (int i = 0; i < 10; i++) begin
      idx = $urandom_range(0, OPD_WORDS-1); d = $urandom; be = NB'($urandom_range(0, (1<<NB)-1));
      wr(32'(4*idx), d, be);
      m_stg[idx] = merge(m_stg[idx], d, be);
      rd(32'(4*idx));
      n_checks++; if (rd_e !== 1'b0 || rd_d !== m_stg[idx]) begin n_errors++; $display("FAIL bl_random[%0d]: got err=%b %h, required err=0 %h", idx, rd_e, rd_d, m_stg[idx]); end
    end
  endtask

  task automatic test_errors();
    int j;
    rd(RES_OFF + 32'h4);
    n_checks++; if (rd_v !== 1'b1 || rd_e !== 1'b0 || rd_d !== m_res[1]) begin n_errors++; $display("FAIL res_read_word1: got v=%b e=%b %h, required 1/0 %h", rd_v, rd_e, rd_d, m_res[1]); end
    rd(32'h002);
    n_checks++; if (rd_e !== 1'b1 || rd_d !== '0) begin n_errors++; $display("FAIL misaligned: got err=%b %h, required 1/0", rd_e, rd_d); end
    rd(32'h400);
    n_checks++; if (rd_e !== 1'b1) begin n_errors++; $display("FAIL unmapped_gap: got err=%b, required 1", rd_e); end
    bus_xfer(1'b0, BASE - 32'h4, '0, '0, rd_d, rd_e, rd_v);
    n_checks++; if (rd_e !== 1'b1) begin n_errors++; $display("FAIL below_base: got err=%b, required 1", rd_e); end
    rd(32'(4*(OPD_WORDS-1)));
    n_checks++; if (rd_e !== 1'b0 || rd_d !== m_stg[OPD_WORDS-1]) begin n_errors++; $display("FAIL opd_last: got err=%b %h, required 0 %h", rd_e, rd_d, m_stg[OPD_WORDS-1]); end
    rd(32'(4*OPD_WORDS));
    n_checks++; if (rd_e !== 1'b1) begin n_errors++; $display("FAIL opd_past_end: got err=%b, required 1", rd_e); end
    rd(RES_OFF + 32'(4*(RES_WORDS-1)));
    n_checks++; if (rd_e !== 1'b0 || rd_d !== m_res[RES_WORDS-1]) begin n_errors++; $display("FAIL res_last: got err=%b %h, required 0 %h", rd_e, rd_d, m_res[RES_WORDS-1]); end
    rd(RES_OFF + 32'(4*RES_WORDS));
    n_checks++; if (rd_e !== 1'b1) begin n_errors++; $display("FAIL res_past_end: got err=%b, required 1", rd_e); end
    wr(CTRL_OFF, 32'h100, 4'hF);
    n_checks++; if (rd_e !== 1'b1) begin n_errors++; $display("FAIL start_mode0_err: got err=%b, required 1", rd_e); end
    rd(STATUS_OFF);
    n_checks++; if (rd_d !== exp_status()) begin n_errors++; $display("FAIL start_mode0_status: got %h, required %h", rd_d, exp_status()); end
    @(negedge clk); core_done = 1'b1; @(negedge clk); core_done = 1'b0;
    rd(STATUS_OFF);
    n_checks++; if (rd_d !== exp_status() || irq !== 1'b0) begin n_errors++; $display("FAIL done_in_idle: got %h irq=%b, required %h irq=0", rd_d, irq, exp_status()); end
    for (int i = 0; i < 4; i++) begin
      j = $urandom_range(0, RES_WORDS-1);
      rd(RES_OFF + 32'(4*j));
      n_checks++; if (rd_d !== m_res[j]) begin n_errors++; $display("FAIL res_random[%0d]: got %h, required %h", j, rd_d, m_res[j]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] e, d;
    logic [NB-1:0] be;
    bit pend, pend_rd, w;
    int idx;
    pend = 0; pend_rd = 0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (pend) begin
        n_checks++; if (bus.valid_Resp !== 1'b1 || bus.err_Resp !== 1'b0 || bus.ready_Req !== 1'b1) begin n_errors++; $display("FAIL b2b_resp[%0d]: got v=%b e=%b rdy=%b, required 1/0/1", i, bus.valid_Resp, bus.err_Resp, bus.ready_Req); end
        if (pend_rd) begin
          e = exp_q.pop_front();
          n_checks++; if (bus.data_Resp !== e) begin n_errors++; $display("FAIL b2b_data[%0d]: got %h, required %h", i, bus.data_Resp, e); end
        end
      end
      if (i == 20) begin
        bus.valid_Req = 1'b0; pend = 0;
      end else begin
        w = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 7);
        d = $urandom; be = NB'($urandom_range(1, (1<<NB)-1));
        bus.valid_Req = 1'b1; bus.wen_Req = w; bus.addr_Req = BASE + 32'(4*idx);
        bus.data_Req = d; bus.bytelane_Req = be;
        if (w) m_stg[idx] = merge(m_stg[idx], d, be);
        else exp_q.push_back(m_stg[idx]);
        pend = 1; pend_rd = !w;
      end
    end
    bus.wen_Req = 1'b0;
  endtask

  task automatic test_commit_done();
    logic [DW-1:0] d;
    bit any_err;
    any_err = 0;
    for (int i = 0; i < OPD_WORDS; i++) begin
      d = $urandom; wr(32'(4*i), d, 4'hF); m_stg[i] = d;
      if (rd_e !== 1'b0) any_err = 1;
    end
    n_checks++; if (any_err) begin n_errors++; $display("FAIL fill_err: got err during fill, required none"); end
    wr(CTRL_OFF, 32'h101, 4'hF);
    m_mode = 2'd1; m_busy = 1;
    n_checks++; if (bus.ready_Req !== 1'b0 || core_start !== 1'b0) begin n_errors++; $display("FAIL commit_cycle: got rdy=%b start=%b, required 0/0", bus.ready_Req, core_start); end
    n_checks++; if (opd_flat !== live_flat()) begin n_errors++; $display("FAIL commit_live_early: operands changed before commit"); end
    for (int i = 0; i < OPD_WORDS; i++) m_live[i] = m_stg[i];
    @(negedge clk);
    n_checks++; if (bus.ready_Req !== 1'b1 || core_start !== 1'b1 || core_mode !== 2'd1) begin n_errors++; $display("FAIL start_pulse: got rdy=%b start=%b mode=%0d, required 1/1/1", bus.ready_Req, core_start, core_mode); end
    n_checks++; if (opd_flat !== live_flat()) begin n_errors++; $display("FAIL opd_committed: got %h, required %h", opd_flat[DW-1:0], m_live[0]); end
    @(negedge clk);
    n_checks++; if (core_start !== 1'b0) begin n_errors++; $display("FAIL start_one_cycle: got %b, required 0", core_start); end
    rd(STATUS_OFF);
    n_checks++; if (rd_d !== exp_status()) begin n_errors++; $display("FAIL status_busy: got %h, required %h", rd_d, exp_status()); end
    repeat (5) @(negedge clk);
    core_done = 1'b1; @(negedge clk); core_done = 1'b0;
    m_busy = 0; m_done = 1;
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_on_done: got %b, required 1", irq); end
    rd(STATUS_OFF);
    n_checks++; if (rd_d !== exp_status()) begin n_errors++; $display("FAIL status_done: got %h, required %h", rd_d, exp_status()); end
    wr(STATUS_OFF, 32'h2, 4'hF);
    m_done = 0;
    rd(STATUS_OFF);
    n_checks++; if (rd_d !== exp_status() || irq !== 1'b0) begin n_errors++; $display("FAIL status_w1c: got %h irq=%b, required %h irq=0", rd_d, irq, exp_status()); end
  endtask

  task automatic test_timeout();
    bit early;
    wr(CTRL_OFF, 32'h102, 4'hF);
    m_mode = 2'd2; m_busy = 1; early = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (irq !== 1'b0) early = 1;
    end
    n_checks++; if (early) begin n_errors++; $display("FAIL timeout_early: irq rose before %0d run cycles", TIMEOUT); end
    @(negedge clk);
    m_busy = 0; m_to = 1;
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL timeout_irq: got %b, required 1", irq); end
    rd(STATUS_OFF);
    n_checks++; if (rd_d !== exp_status()) begin n_errors++; $display("FAIL status_timeout: got %h, required %h", rd_d, exp_status()); end
    wr(STATUS_OFF, 32'h4, 4'hF);
    m_to = 0;
    wr(CTRL_OFF, 32'h102, 4'hF);
    m_busy = 1;
    repeat (TIMEOUT) @(negedge clk);
    core_done = 1'b1; @(negedge clk); core_done = 1'b0;
    m_busy = 0; m_done = 1;
    rd(STATUS_OFF);
    n_checks++; if (rd_d !== exp_status()) begin n_errors++; $display("FAIL done_on_timeout_cycle: got %h, required %h", rd_d, exp_status()); end
  endtask

  task automatic test_reject();
    wr(STATUS_OFF, 32'hE, 4'hF);
    m_done = 0; m_to = 0; m_rej = 0;
    wr(CTRL_OFF, 32'h102, 4'hF);
    m_mode = 2'd2; m_busy = 1;
    wr(CTRL_OFF, 32'h103, 4'hF);
    m_rej = 1;
    n_checks++; if (rd_e !== 1'b0) begin n_errors++; $display("FAIL reject_err: got %b, required 0", rd_e); end
    rd(STATUS_OFF);
    n_checks++; if (rd_d !== exp_status()) begin n_errors++; $display("FAIL status_rejected: got %h, required %h", rd_d, exp_status()); end
    rd(CTRL_OFF);
    n_checks++; if (rd_d !== DW'(m_mode) || core_mode !== m_mode) begin n_errors++; $display("FAIL mode_kept: got %h/%0d, required %0d", rd_d, core_mode, m_mode); end
    wr(RES_OFF, 32'hCAFE_F00D, 4'hF);
    n_checks++; if (rd_e !== 1'b1 || rd_d !== '0) begin n_errors++; $display("FAIL res_write_err: got err=%b %h, required 1/0", rd_e, rd_d); end
    rd(RES_OFF);
    n_checks++; if (rd_d !== m_res[0]) begin n_errors++; $display("FAIL res_unchanged: got %h, required %h", rd_d, m_res[0]); end
    // W1C of done and rejected landing on the same edge as core_done
    @(negedge clk);
    bus.valid_Req = 1'b1; bus.wen_Req = 1'b1; bus.addr_Req = BASE + STATUS_OFF;
    bus.data_Req = 32'hA; bus.bytelane_Req = 4'hF; core_done = 1'b1;
    @(negedge clk);
    bus.valid_Req = 1'b0; bus.wen_Req = 1'b0; core_done = 1'b0;
    m_busy = 0; m_done = 1; m_rej = 0;
    n_checks++; if (bus.valid_Resp !== 1'b1 || bus.err_Resp !== 1'b0 || irq !== 1'b1) begin n_errors++; $display("FAIL w1c_vs_set_resp: got v=%b e=%b irq=%b, required 1/0/1", bus.valid_Resp, bus.err_Resp, irq); end
    rd(STATUS_OFF);
    n_checks++; if (rd_d !== exp_status()) begin n_errors++; $display("FAIL w1c_vs_set_status: got %h, required %h", rd_d, exp_status()); end
  endtask

  task automatic test_reset_mid_run();
    wr(CTRL_OFF, 32'h103, 4'hF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (core_start !== 1'b0 || irq !== 1'b0 || core_mode !== 2'd0) begin n_errors++; $display("FAIL midrun_outputs: got start=%b irq=%b mode=%0d, required 0/0/0", core_start, irq, core_mode); end
    n_checks++; if (opd_flat !== '0) begin n_errors++; $display("FAIL midrun_opd_flat: got %h.., required 0", opd_flat[DW-1:0]); end
    n_checks++; if (bus.ready_Req !== 1'b1 || bus.valid_Resp !== 1'b0 || dbg_state !== IDLE) begin n_errors++; $display("FAIL midrun_bus: got rdy=%b v=%b st=%0d, required 1/0/IDLE", bus.ready_Req, bus.valid_Resp, dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rd(STATUS_OFF);
    n_checks++; if (rd_d !== exp_status()) begin n_errors++; $display("FAIL midrun_status: got %h, required %h", rd_d, exp_status()); end
    rd(32'h14);
    n_checks++; if (rd_d !== m_stg[5]) begin n_errors++; $display("FAIL midrun_staging: got %h, required %h", rd_d, m_stg[5]); end
  endtask

  initial begin
    rst = 1'b1;
    bus.valid_Req = 1'b0; bus.wen_Req = 1'b0; bus.addr_Req = '0;
    bus.data_Req = '0; bus.bytelane_Req = '0; core_done = 1'b0;
    model_reset();
    for (int j = 0; j < RES_WORDS; j++) m_res[j] = $urandom;
    m_res[1] = 32'hDEAD_BEEF;
    drive_res();
    test_reset();
    test_bytelane();
    test_errors();
    test_back_to_back();
    test_commit_done();
    test_timeout();
    test_reject();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kyber_mmio_ctrl.md
Name: kyber_mmio_ctrl

Overview:
Parametrised memory-mapped front-end and sequencer for the Baby Kyber datapath (KeyGeneration/Encrypt/Decrypt cores). It adds a valid/ready bus handshake and byte-lane write masking to the operand bus. Writes land in staging registers. A CTRL write commits staging to live operand registers, starts the selected operation, and tracks completion, timeout and sticky status.

Parameters:
K, 2, module rank (polynomial vector length)
N, 4, coefficients per polynomial
DW, 32, data/coefficient width (multiple of 8)
BASE, 32'h4000_7000, bus base address
TIMEOUT, 1024, max RUN cycles before abort (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
valid_Req  in  1  request valid
ready_Req  out  1  request accepted when valid_Req&ready_Req
wen_Req  in  1  1=write, 0=read
addr_Req  in  32  byte address
data_Req  in  DW  write data
bytelane_Req  in  DW/8  write byte enables
valid_Resp  out  1  response valid, one cycle pulse
data_Resp  out  DW  read data (0 on writes/errors)
err_Resp  out  1  access error
opd_flat  out  OPD_WORDS*DW  live operands: A, s, e, r, e1, e2, message
res_flat  in  RES_WORDS*DW  core results: pk, ciphertext, decoded message
core_mode  out  2  1=keygen, 2=encrypt, 3=decrypt
core_start  out  1  one-cycle start pulse
core_done  in  1  completion pulse from selected core
irq  out  1  done_sticky | timeout_sticky

Behaviour:
- Word counts: A=K*K*N, s=e=r=e1=K*N, e2=N, msg=1, OPD_WORDS=sum. RES_WORDS=K*K*N+K*N+(K+1)*N+1.
- Map (byte offsets from BASE, word aligned):
  - 0x000 + 4*i: operand staging word i, in order A, s, e, r, e1, e2, msg. Read/write.
  - 0x800 + 4*j: result word j. Read-only.
  - 0xF00: CTRL. Bits[1:0] mode; bit8 start. Reads return the last mode.
  - 0xF04: STATUS. Bit0 busy, bit1 done, bit2 timeout, bit3 rejected, bits[5:4] last mode. Bits1..3 are write-1-to-clear.
- Handshake:
  - ready_Req=1 in all states except COMMIT.
  - An accepted request produces valid_Resp=1 on the next cycle with data_Resp and err_Resp. No back-to-back stall otherwise.
- Operand reads return the staging value.
- Byte-lane writes: byte b updates only if bytelane_Req[b]. All-zero lanes are accepted, no state change, err=0.
- err_Resp=1 for any of these; the access has no side effect:
  - unmapped address
  - misaligned addr[1:0]!=0
  - write to the result window
  - CTRL write with start=1 and mode=0
- Staging writes are allowed in any state; live operands change only in COMMIT.
- FSM:
  - IDLE: CTRL write with start=1 and valid mode -> COMMIT. Mode is latched.
  - COMMIT (1 cycle): live <= staging -> RUN. core_start=1 during the first RUN cycle. Timeout counter cleared.
  - RUN: core_done -> IDLE, done_sticky set. Counter reaching TIMEOUT-1 without core_done -> IDLE, timeout_sticky set. busy=1 in COMMIT and RUN.
  - CTRL start while not IDLE: ignored, rejected_sticky set, err_Resp=0.
- Simultaneous events:
  - core_done on the timeout cycle: done wins, timeout not set.
  - core_done outside RUN: ignored.
  - W1C in the same cycle as a hardware set: the set wins.
- Reset (async, any state, including mid-RUN) returns to IDLE. Staging, live, mode, counters and stickies are cleared. Outputs reset to: ready_Req=1, valid_Resp=0, data_Resp=0, err_Resp=0, core_start=0, core_mode=0, irq=0, opd_flat=0.
- Address decode is combinational on addr_Req; all outputs are registered except ready_Req.

Decomposition:
- Package kyber_mmio_pkg holds:
  - the state enum (IDLE, COMMIT, RUN)
  - mode constants
  - offset constants (OPD_OFF, RES_OFF, CTRL_OFF, STATUS_OFF)
  - STATUS bit indices
  - word-count functions of K and N
- One sub-module, kyber_bytelane_reg: a DW-wide register with per-byte enable and async reset, instantiated per staging word.

Test Plan:
- Reset mid-RUN (assert rst during RUN) -> busy=0, core_start=0, opd_flat=0, STATUS reads 0.
- Write A word 0 = 0x11223344 with bytelane 4'b0101, then read -> 0x00220044. opd_flat is unchanged until commit.
- Fill all operands, then write CTRL=0x101 -> ready_Req=0 for 1 cycle, core_start pulses with mode=1 and opd_flat = staged values. core_done after 10 cycles -> STATUS=0x12 and irq=1. Then W1C 0x2 -> STATUS=0x10 and irq=0.
- Write CTRL=0x102 and withhold core_done -> after TIMEOUT cycles STATUS bit2=1, busy=0. Also drive core_done on exactly the timeout cycle -> bit1=1, bit2=0.
- While busy, write CTRL=0x103 -> rejected bit3=1 and the mode stays 2. Write to BASE+0x800 -> err_Resp=1 and res_flat readback is unchanged.
- Read BASE+0x804 with res_flat word1=0xDEADBEEF -> data_Resp=0xDEADBEEF one cycle later. Read BASE+0x002 -> err_Resp=1, data_Resp=0.
